// File: rtl/road_object_tracker_if.sv
// Handshake bundle between the game FSM/keyboard side
// and the road object tracker.
interface road_object_tracker_if #(
  parameter int ROW_W = 3
);
  logic             Run;
  logic             Step;
  logic             LeftEn;
  logic             RightEn;
  logic             HitAck;
  logic [1:0]       PlayerLane;
  logic             HitEn;
  logic             CoinEn;
  logic             PoliceEn;
  logic [2:0]       ObjValid;
  logic [2:0]       ObjType;
  logic [3*ROW_W-1:0] ObjRow;

  modport master (
    output Run, Step, LeftEn, RightEn, HitAck,
    input  PlayerLane, HitEn, CoinEn, PoliceEn,
    input  ObjValid, ObjType, ObjRow
  );

  modport slave (
    input  Run, Step, LeftEn, RightEn, HitAck,
    output PlayerLane, HitEn, CoinEn, PoliceEn,
    output ObjValid, ObjType, ObjRow
  );
endinterface

// File: rtl/road_object_tracker.sv
// Player lane, per-lane scrolling objects, spawn LFSR
// and hit events for a 3-lane road game.
module road_object_tracker #(
  parameter int         NUM_ROWS  = 8,
  parameter int         ROW_W     = 3,
  parameter int         SPAWN_GAP = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic Clock,
  input logic Reset,
  road_object_tracker_if.slave bus
);
  localparam logic [ROW_W-1:0] LAST = ROW_W'(NUM_ROWS - 1);
  localparam int GW = $clog2(SPAWN_GAP + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t           state;
  logic [1:0]       lane;
  logic [2:0]       vld;
  logic [2:0]       typ;
  logic [ROW_W-1:0] row [3];
  logic [7:0]       lfsr;
  logic [GW-1:0]    gap;
  logic             hit;
  logic             coin;
  logic             police;

  logic             collide;
  logic             lane_typ;
  logic [2:0]       lane_mask;
  logic [1:0]       lane_nxt;
  logic [3:0]       vld4;
  logic             spawn;
  logic [2:0]       step_vld;
  logic [2:0]       step_typ;
  logic [ROW_W-1:0] step_row [3];
  logic [GW-1:0]    gap_nxt;
  logic [7:0]       lfsr_nxt;

  // Collision test against the slot under the player
  always_comb begin
    collide   = 1'b0;
    lane_typ  = 1'b0;
    lane_mask = '0;
    for (int i = 0; i < 3; i++) begin
      if (lane == 2'(i)) begin
        lane_mask[i] = 1'b1;
        lane_typ     = typ[i];
        collide      = vld[i] && (row[i] == LAST);
      end
    end
  end

  // Saturating lane move; both pulses cancel
  always_comb begin
    lane_nxt = lane;
    unique case (1'b1)
      bus.LeftEn && !bus.RightEn:
        if (lane != 2'd0) lane_nxt = lane - 2'd1;
      bus.RightEn && !bus.LeftEn:
        if (lane != 2'd2) lane_nxt = lane + 2'd1;
      default: ;
    endcase
  end

  // Lane code 3 is treated as occupied so it never spawns
  assign vld4  = {1'b1, vld};
  assign spawn = (gap == '0) && !vld4[lfsr[1:0]];

  // Scroll result: advance or retire, then drop in a spawn
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      step_vld[i] = vld[i] && (row[i] != LAST);
      step_row[i] = step_vld[i] ? row[i] + 1'b1 : row[i];
      step_typ[i] = typ[i];
      if (spawn && (lfsr[1:0] == 2'(i))) begin
        step_vld[i] = 1'b1;
        step_row[i] = '0;
        step_typ[i] = lfsr[2];
      end
    end
  end

  assign gap_nxt = spawn ? GW'(SPAWN_GAP) :
                   (gap != '0) ? gap - 1'b1 : gap;

  assign lfsr_nxt = {lfsr[6:0],
                     lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Game-play state machine and all registered state
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      lane   <= 2'd1;
      vld    <= '0;
      typ    <= '0;
      row    <= '{default: '0};
      lfsr   <= LFSR_SEED;
      gap    <= '0;
      hit    <= 1'b0;
      coin   <= 1'b0;
      police <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Run) state <= RUN;
        end
        RUN: begin
          if (!bus.Run) begin
            state <= IDLE;
          end else if (collide) begin
            state  <= HOLD;
            hit    <= 1'b1;
            coin   <= lane_typ;
            police <= !lane_typ;
            vld    <= vld & ~lane_mask;
          end else begin
            lane <= lane_nxt;
            if (bus.Step) begin
              vld  <= step_vld;
              typ  <= step_typ;
              row  <= step_row;
              gap  <= gap_nxt;
              lfsr <= lfsr_nxt;
            end
          end
        end
        HOLD: begin
          if (bus.HitAck) begin
            hit    <= 1'b0;
            coin   <= 1'b0;
            police <= 1'b0;
            state  <= bus.Run ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.PlayerLane = lane;
  assign bus.HitEn      = hit;
  assign bus.CoinEn     = coin;
  assign bus.PoliceEn   = police;
  assign bus.ObjValid   = vld;
  assign bus.ObjType    = typ;
  assign bus.ObjRow     = {row[2], row[1], row[0]};
endmodule

// File: tb/tb_road_object_tracker.sv
// Scenario and randomized checks of road_object_tracker
// against a behavioural game model.
module tb_road_object_tracker;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  road_object_tracker_if #(.ROW_W(3)) bus ();

  road_object_tracker #(
    .NUM_ROWS(8), .ROW_W(3), .SPAWN_GAP(3), .LFSR_SEED(8'hA5)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: 0 idle, 1 playing, 2 waiting for ack
  int m_mode;
  int m_lane;
  int m_row [3];
  bit m_valid [3];
  bit m_type [3];
  int m_gap;
  int m_lfsr;
  bit m_hit, m_coin, m_police;

  task automatic model_update(input bit rst, run, step,
                              input bit l, r, ack);
    int  sl;
    bit  can;
    if (rst) begin
      m_mode = 0; m_lane = 1; m_gap = 0; m_lfsr = 'hA5;
      m_hit = 0; m_coin = 0; m_police = 0;
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 0; m_type[i] = 0; m_row[i] = 0;
      end
      return;
    end
    if (m_mode == 0) begin
      if (run) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!run) m_mode = 0;
      else if (m_valid[m_lane] && m_row[m_lane] == 7) begin
        m_mode = 2; m_hit = 1;
        m_coin = m_type[m_lane]; m_police = !m_type[m_lane];
        m_valid[m_lane] = 0;
      end else begin
        if (l && !r && m_lane > 0) m_lane = m_lane - 1;
        if (r && !l && m_lane < 2) m_lane = m_lane + 1;
        if (step) begin
          sl = m_lfsr % 4;
          can = 0;
          if (m_gap == 0 && sl < 3) can = !m_valid[sl];
          for (int i = 0; i < 3; i++)
            if (m_valid[i]) begin
              if (m_row[i] == 7) m_valid[i] = 0;
              else m_row[i] = m_row[i] + 1;
            end
          if (can) begin
            m_valid[sl] = 1; m_row[sl] = 0;
            m_type[sl] = (m_lfsr >> 2) & 1; m_gap = 3;
          end else if (m_gap > 0) m_gap = m_gap - 1;
          m_lfsr = ((m_lfsr << 1) |
                    ($countones(m_lfsr & 'hB8) & 1)) & 'hFF;
        end
      end
    end else begin
      if (ack) begin
        m_hit = 0; m_coin = 0; m_police = 0;
        m_mode = run ? 1 : 0;
      end
    end
  endtask

  task automatic cycle(input bit rst, run, step,
                       input bit l, r, ack);
    Reset = rst; bus.Run = run; bus.Step = step;
    bus.LeftEn = l; bus.RightEn = r; bus.HitAck = ack;
    @(posedge Clock);
    model_update(rst, run, step, l, r, ack);
    #1;
  endtask

  function automatic logic [8:0] m_rows();
    return {3'(m_row[2]), 3'(m_row[1]), 3'(m_row[0])};
  endfunction

  function automatic logic [2:0] m_vbits();
    return {m_valid[2], m_valid[1], m_valid[0]};
  endfunction

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.PlayerLane !== 2'd1 || bus.ObjValid !== 3'b000 ||
        bus.HitEn !== 1'b0 || bus.CoinEn !== 1'b0 ||
        bus.PoliceEn !== 1'b0) begin
      errors++;
      $display("FAIL reset: lane=%0d valid=%b hit=%b%b%b want 1 000 000",
               bus.PlayerLane, bus.ObjValid, bus.HitEn,
               bus.CoinEn, bus.PoliceEn);
    end
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, k[0], 0, 0);
    checks++;
    if (bus.PlayerLane !== 2'd1 || bus.ObjValid !== 3'b000 ||
        bus.HitEn !== 1'b0) begin
      errors++;
      $display("FAIL idle_frozen: lane=%0d valid=%b hit=%b want 1 000 0",
               bus.PlayerLane, bus.ObjValid, bus.HitEn);
    end
  endtask

  task automatic test_coin_hit();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    checks++;
    if (bus.ObjValid !== 3'b010 || bus.ObjType[1] !== 1'b1 ||
        bus.ObjRow[3 +: 3] !== 3'd0) begin
      errors++;
      $display("FAIL first_spawn: valid=%b type1=%b row1=%0d want 010 1 0",
               bus.ObjValid, bus.ObjType[1], bus.ObjRow[3 +: 3]);
    end
    for (int k = 1; k <= 7; k++) begin
      cycle(0, 1, 1, 0, 0, 0);
      checks++;
      if (bus.ObjValid[1] !== 1'b1 || bus.ObjRow[3 +: 3] !== 3'(k) ||
          bus.ObjRow !== m_rows()) begin
        errors++;
        $display("FAIL scroll: row1=%0d rows=%h want %0d %h",
                 bus.ObjRow[3 +: 3], bus.ObjRow, k, m_rows());
      end
    end
    cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (bus.HitEn !== 1'b1 || bus.CoinEn !== 1'b1 ||
        bus.PoliceEn !== 1'b0 || bus.ObjValid[1] !== 1'b0) begin
      errors++;
      $display("FAIL coin_hit: hit/coin/pol=%b%b%b v1=%b want 110 0",
               bus.HitEn, bus.CoinEn, bus.PoliceEn, bus.ObjValid[1]);
    end
    cycle(0, 1, 0, 0, 0, 1);
    checks++;
    if ({bus.HitEn, bus.CoinEn, bus.PoliceEn} !== 3'b000) begin
      errors++;
      $display("FAIL hit_ack: hit/coin/pol=%b%b%b want 000",
               bus.HitEn, bus.CoinEn, bus.PoliceEn);
    end
    cycle(0, 1, 0, 0, 1, 0);
    checks++;
    if (bus.PlayerLane !== 2'd2) begin
      errors++;
      $display("FAIL back_to_run: lane=%0d want 2", bus.PlayerLane);
    end
  endtask

  task automatic test_lane_moves();
    logic [1:0] exp_l [3];
    logic [1:0] exp_r [3];
    exp_l = '{2'd0, 2'd0, 2'd0};
    exp_r = '{2'd1, 2'd2, 2'd2};
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 1, 0, 0);
      checks++;
      if (bus.PlayerLane !== exp_l[k]) begin
        errors++;
        $display("FAIL left_%0d: lane=%0d want %0d",
                 k, bus.PlayerLane, exp_l[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0, 1, 0);
      checks++;
      if (bus.PlayerLane !== exp_r[k]) begin
        errors++;
        $display("FAIL right_%0d: lane=%0d want %0d",
                 k, bus.PlayerLane, exp_r[k]);
      end
    end
    cycle(0, 1, 0, 1, 1, 0);
    checks++;
    if (bus.PlayerLane !== 2'd2) begin
      errors++;
      $display("FAIL both_pulses: lane=%0d want 2", bus.PlayerLane);
    end
  endtask

  task automatic test_police_move();
    bit         found = 0;
    logic [8:0] held;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3000 && !found; k++) begin
      if (m_mode == 2) cycle(0, 1, 0, 0, 0, 1);
      else if (m_lane != 1) cycle(0, 1, 0, 0, 1, 0);
      else if (m_valid[0] && !m_type[0] && m_row[0] == 7 &&
               !(m_valid[1] && m_row[1] == 7)) found = 1;
      else cycle(0, 1, 1, 0, 0, 0);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL police_search: found=0 want 1");
      return;
    end
    cycle(0, 1, 0, 1, 0, 0);
    checks++;
    if (bus.PlayerLane !== 2'd0 || bus.HitEn !== 1'b0) begin
      errors++;
      $display("FAIL move_into_police: lane=%0d hit=%b want 0 0",
               bus.PlayerLane, bus.HitEn);
    end
    cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (bus.HitEn !== 1'b1 || bus.PoliceEn !== 1'b1 ||
        bus.CoinEn !== 1'b0 || bus.ObjValid[0] !== 1'b0) begin
      errors++;
      $display("FAIL police_hit: hit/coin/pol=%b%b%b v0=%b want 101 0",
               bus.HitEn, bus.CoinEn, bus.PoliceEn, bus.ObjValid[0]);
    end
    held = bus.ObjRow;
    for (int k = 0; k < 3; k++) cycle(0, 1, 1, 0, 0, 0);
    checks++;
    if (bus.ObjRow !== held || bus.ObjRow !== m_rows() ||
        bus.HitEn !== 1'b1) begin
      errors++;
      $display("FAIL hold_frozen: rows=%h hit=%b want %h 1",
               bus.ObjRow, bus.HitEn, m_rows());
    end
    cycle(0, 1, 0, 0, 0, 1);
  endtask

  task automatic test_exit();
    int j = -1;
    for (int k = 0; k < 3000 && j < 0; k++) begin
      if (m_mode != 1) cycle(0, 1, 0, 0, 0, 1);
      else if (m_valid[m_lane] && m_row[m_lane] == 7)
        cycle(0, 1, 0, 0, 0, 0);
      else begin
        for (int i = 0; i < 3; i++)
          if (i != m_lane && m_valid[i] && m_row[i] == 7) j = i;
        if (j < 0) cycle(0, 1, 1, 0, 0, 0);
      end
    end
    checks++;
    if (j < 0) begin
      errors++;
      $display("FAIL exit_search: found=0 want 1");
      return;
    end
    cycle(0, 1, 1, 0, 0, 0);
    checks++;
    if (bus.ObjValid[j] !== 1'b0 || bus.HitEn !== 1'b0 ||
        bus.ObjValid !== m_vbits()) begin
      errors++;
      $display("FAIL exit_lane%0d: valid=%b hit=%b want %b 0",
               j, bus.ObjValid, bus.HitEn, m_vbits());
    end
  endtask

  task automatic test_freeze();
    logic [8:0] rows;
    logic [2:0] vb;
    logic [1:0] ln;
    if (m_mode == 2) cycle(0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) cycle(0, 1, 1, 0, 0, 0);
    if (m_mode == 2) cycle(0, 1, 0, 0, 0, 1);
    rows = m_rows(); vb = m_vbits(); ln = 2'(m_lane);
    cycle(0, 0, 1, 1, 0, 0);
    for (int k = 0; k < 5; k++)
      cycle(0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 1), 0);
    checks++;
    if (bus.ObjRow !== rows || bus.ObjValid !== vb ||
        bus.PlayerLane !== ln) begin
      errors++;
      $display("FAIL run_low_frozen: rows=%h v=%b lane=%0d want %h %b %0d",
               bus.ObjRow, bus.ObjValid, bus.PlayerLane, rows, vb, ln);
    end
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    checks++;
    if (bus.ObjRow !== m_rows() || bus.ObjValid !== m_vbits()) begin
      errors++;
      $display("FAIL resume: rows=%h v=%b want %h %b",
               bus.ObjRow, bus.ObjValid, m_rows(), m_vbits());
    end
  endtask

  task automatic test_reset_in_hold();
    for (int k = 0; k < 3000 && m_mode != 2; k++)
      cycle(0, 1, 1, 0, 0, 0);
    checks++;
    if (bus.HitEn !== 1'b1) begin
      errors++;
      $display("FAIL reach_hold: hit=%b want 1", bus.HitEn);
    end
    cycle(1, 1, 1, 1, 0, 1);
    checks++;
    if (bus.PlayerLane !== 2'd1 || bus.ObjValid !== 3'b000 ||
        bus.ObjType !== 3'b000 || bus.ObjRow !== 9'd0 ||
        {bus.HitEn, bus.CoinEn, bus.PoliceEn} !== 3'b000) begin
      errors++;
      $display("FAIL reset_in_hold: lane=%0d v=%b t=%b rows=%h hit=%b",
               bus.PlayerLane, bus.ObjValid, bus.ObjType,
               bus.ObjRow, bus.HitEn);
    end
  endtask

  task automatic test_random();
    bit run, step, l, r, ack;
    cycle(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      run  = ($urandom_range(0, 19) != 0);
      step = $urandom_range(0, 1);
      l    = ($urandom_range(0, 4) == 0);
      r    = ($urandom_range(0, 4) == 0);
      ack  = m_hit ? ($urandom_range(0, 2) == 0)
                   : ($urandom_range(0, 9) == 0);
      cycle(0, run, step, l, r, ack);
      checks++;
      if (bus.PlayerLane !== 2'(m_lane) || bus.ObjValid !== m_vbits() ||
          bus.ObjType !== {m_type[2], m_type[1], m_type[0]} ||
          bus.ObjRow !== m_rows() || bus.HitEn !== m_hit ||
          bus.CoinEn !== m_coin || bus.PoliceEn !== m_police) begin
        errors++;
        $display("FAIL random_%0d: lane=%0d v=%b t=%b rows=%h h=%b%b%b want %0d %b %b %h %b%b%b",
                 k, bus.PlayerLane, bus.ObjValid, bus.ObjType,
                 bus.ObjRow, bus.HitEn, bus.CoinEn, bus.PoliceEn,
                 m_lane, m_vbits(), {m_type[2], m_type[1], m_type[0]},
                 m_rows(), m_hit, m_coin, m_police);
      end
    end
  endtask

  initial begin
    bus.Run = 0; bus.Step = 0; bus.LeftEn = 0;
    bus.RightEn = 0; bus.HitAck = 0;
    test_reset();
    test_coin_hit();
    test_lane_moves();
    test_police_move();
    test_exit();
    test_freeze();
    test_reset_in_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/road_object_tracker.md
Name: road_object_tracker

Overview:
- Tracks the player car's lane and the coin/police objects scrolling down a 3-lane road.
- Raises the hit events that drive the game-state FSM from DRIVING into HIT, then into COIN or LOSE.
- Sits between the keyboard decoder (LeftEn/RightEn pulses) and the game-state FSM (Run = DriveEn, HitAck = FSM leaving HIT).
- Also provides object positions to the renderer.

Parameters:
- NUM_ROWS, 8: rows per lane; objects enter at row 0; the player occupies row NUM_ROWS-1.
- ROW_W, 3: row index width, equal to clog2(NUM_ROWS).
- SPAWN_GAP, 3: number of Steps to wait after a spawn before the next spawn is allowed.
- LFSR_SEED, 8'hA5: reset value of the spawn LFSR; must be nonzero.

Ports:
- Clock  in  1  game clock.
- Reset  in  1  synchronous, active-high.
- Run  in  1  game running (DriveEn from the FSM); 0 freezes the block.
- Step  in  1  1-cycle scroll tick.
- LeftEn  in  1  1-cycle move-left pulse.
- RightEn  in  1  1-cycle move-right pulse.
- HitAck  in  1  1-cycle pulse; FSM has consumed the pending hit.
- PlayerLane  out  2  current player lane, range 0..2.
- HitEn  out  1  hit pending.
- CoinEn  out  1  pending hit is a coin.
- PoliceEn  out  1  pending hit is police.
- ObjValid  out  3  per-lane object present; bit i = lane i.
- ObjType  out  3  per-lane object type; 1 = coin, 0 = police.
- ObjRow  out  3*ROW_W  per-lane row; lane i at bits [i*ROW_W +: ROW_W].

Behaviour:
- Reset (sync, Reset=1 at an edge) sets:
  - state IDLE, PlayerLane=1
  - ObjValid=0, ObjType=0, ObjRow=0
  - HitEn=CoinEn=PoliceEn=0
  - LFSR=LFSR_SEED, gap counter=0
- Reset overrides every other input, including in HOLD.
- Storage: one object slot per lane, each holding valid, type and row. All outputs are registered.
- States:
  - IDLE: everything frozen. Run=1 -> RUN.
  - RUN: normal play. Run=0 -> IDLE. A collision -> HOLD.
  - HOLD: HitEn held high. HitAck -> RUN if Run=1, else IDLE.
- Collision rule (RUN only):
  - Collision = ObjValid[PlayerLane]=1 and ObjRow[PlayerLane]=NUM_ROWS-1, evaluated on the registered state.
  - On detection, at the next edge: state=HOLD, HitEn=1, CoinEn=ObjType[PlayerLane], PoliceEn=~ObjType[PlayerLane], that slot's valid cleared.
  - In the detecting cycle, collision has priority: Step, LeftEn and RightEn are ignored.
- Lane moves (RUN, no collision):
  - LeftEn: lane-1, saturating at 0.
  - RightEn: lane+1, saturating at 2.
  - Both in the same cycle: no change.
  - Ignored in IDLE and HOLD.
  - Moving into a lane whose object is at row NUM_ROWS-1 causes a collision on the following cycle.
- Step (RUN, no collision):
  - Each valid slot advances: row+1.
  - A slot already at row NUM_ROWS-1 is invalidated instead (the object leaves the road); no wrap-around.
- Spawn, evaluated on the same Step using the pre-advance LFSR value L:
  - Condition: gap counter=0, L[1:0]!=2'b11, and slot L[1:0] invalid.
  - Effect: slot L[1:0] gets valid=1, row=0, type=L[2]; gap counter loads SPAWN_GAP.
  - A newly spawned object does not also advance on that Step.
  - Otherwise the gap counter decrements, saturating at 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts left with feedback into bit 0, once per accepted Step.
- Step, LeftEn, RightEn and Run=0 all in the same cycle: state goes to IDLE and no movement occurs.
- HOLD:
  - Outputs held until HitAck; Step is ignored and the LFSR does not advance.
  - HitAck: HitEn=CoinEn=PoliceEn=0 at the next edge.
  - HitAck outside HOLD is ignored.
  - HitEn and (CoinEn XOR PoliceEn) are always asserted together.

Test Plan:
- Reset with LFSR_SEED=A5 -> PlayerLane=1, ObjValid=000, HitEn=CoinEn=PoliceEn=0, and these hold while Run=0 with Steps applied.
- Run=1, one Step -> ObjValid=010, ObjType[1]=1, lane-1 row=0.
  - 7 further Steps, player stays in lane 1 -> row=7.
  - Next cycle -> HitEn=1, CoinEn=1, PoliceEn=0, ObjValid[1]=0.
  - HitAck -> all hit outputs 0 the following cycle, state back to RUN.
- Three LeftEn pulses from lane 1 -> PlayerLane 0,0,0. Three RightEn pulses -> 1,2,2. LeftEn+RightEn together -> unchanged.
- Police object at row 7 in lane 0, player moves from lane 1 into lane 0 -> PoliceEn=1, CoinEn=0, HitEn=1 one cycle after the move. Steps during HOLD leave all rows unchanged.
- Object at row 7 in a lane the player is not in, Step -> that ObjValid bit clears, no HitEn.
- Drop Run mid-play -> rows and lane frozen through 5 Steps. Reassert Run -> scrolling resumes from the frozen rows. Reset asserted in HOLD -> all reset values next cycle.
